// File: rtl/wb_regfile_pkg.sv
// Pipeline-wide constants shared by the ID/EX/MEM/WB blocks.
package wb_regfile_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  // Registered MEM/WB write-back bundle.
  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              we_hilo;
    logic [DATA_W-1:0] wdata_hi;
    logic [DATA_W-1:0] wdata_lo;
  } wb_bundle_t;
endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair with write-through bypass onto the read outputs.
module hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata_hi,
  input  logic [DATA_W-1:0] wdata_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  logic [DATA_W-1:0] hi_q, lo_q;

  // Both halves always commit together; there is no partial write.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we) begin
      hi_q <= wdata_hi;
      lo_q <= wdata_lo;
    end
  end

  // Bypass the pending write; force zero while reset is held so the
  // bypass path cannot leak write data during reset.
  assign hi = !rst_ ? '0 : (we ? wdata_hi : hi_q);
  assign lo = !rst_ ? '0 : (we ? wdata_lo : lo_q);
endmodule

// File: rtl/wb_regfile.sv
// Write-back commit: 32-entry GPR file with two bypassed decode read
// ports, plus the HI/LO pair.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] wb_i_waddr,
  input  logic              wb_i_wreg,
  input  logic [DATA_W-1:0] wb_i_wdata,
  input  logic              wb_i_we_hilo,
  input  logic [DATA_W-1:0] wb_i_wdata_hi,
  input  logic [DATA_W-1:0] wb_i_wdata_lo,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic [ADDR_W-1:0] id_raddr1,
  input  logic [ADDR_W-1:0] id_raddr2,
  output logic [DATA_W-1:0] id_rdata1,
  output logic [DATA_W-1:0] id_rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int NREG  = 2 ** ADDR_W;
  localparam int NPORT = 2;

  logic [DATA_W-1:0] gpr [NREG];

  logic [NPORT-1:0]             re;
  logic [NPORT-1:0][ADDR_W-1:0] raddr;
  logic [NPORT-1:0][DATA_W-1:0] rdata;

  assign re    = {id_re2, id_re1};
  assign raddr = {id_raddr2, id_raddr1};
  assign id_rdata1 = rdata[0];
  assign id_rdata2 = rdata[1];

  // Commit GPR writes; index 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (wb_i_wreg && (wb_i_waddr != '0)) begin
      gpr[wb_i_waddr] <= wb_i_wdata;
    end
  end

  // Read ports: disabled / r0 / reset -> zero, else bypass, else storage.
  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    assign rdata[p] = (!rst_ || !re[p] || (raddr[p] == '0)) ? '0 :
                      (wb_i_wreg && (wb_i_waddr == raddr[p])) ? wb_i_wdata :
                      gpr[raddr[p]];
  end

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk      (clk),
    .rst_     (rst_),
    .we       (wb_i_we_hilo),
    .wdata_hi (wb_i_wdata_hi),
    .wdata_lo (wb_i_wdata_lo),
    .hi       (hi_o),
    .lo       (lo_o)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Directed and random checks for wb_regfile.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_;
  logic [4:0]  waddr;
  logic        wreg;
  logic [31:0] wdata;
  logic        we_hilo;
  logic [31:0] whi, wlo;
  logic        re1, re2;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2, hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl [32];
  logic [31:0] mhi, mlo;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst_(rst_),
    .wb_i_waddr(waddr), .wb_i_wreg(wreg), .wb_i_wdata(wdata),
    .wb_i_we_hilo(we_hilo), .wb_i_wdata_hi(whi), .wb_i_wdata_lo(wlo),
    .id_re1(re1), .id_re2(re2), .id_raddr1(ra1), .id_raddr2(ra2),
    .id_rdata1(rd1), .id_rdata2(rd2), .hi_o(hi), .lo_o(lo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Move to 1ns after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wreg = 0; waddr = 0; wdata = 0; we_hilo = 0; whi = 0; wlo = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (!re) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (wreg && waddr == ra) return wdata;
    return mdl[ra];
  endfunction

  initial begin
    rst_ = 0; idle();
    re1 = 1; re2 = 1; ra1 = 5; ra2 = 5;
    wreg = 1; waddr = 5; wdata = 32'hCAFE_F00D; we_hilo = 1; whi = 7; wlo = 8;
    #2;
    // Outputs held at zero during reset even with a pending write.
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_hi", hi, 32'h0);
    @(posedge clk); #2;
    chk("rst_wr_ignored", rd2, 32'h0);
    idle();
    #1 rst_ = 1;

    // Write r5 and HI, then reset mid-cycle.
    cyc();
    wreg = 1; waddr = 5; wdata = 32'hDEAD_BEEF; we_hilo = 1; whi = 1; wlo = 0;
    cyc(); idle();
    #2;
    chk("r5_stored", rd1, 32'hDEAD_BEEF);
    chk("hi_stored", hi, 32'h1);
    rst_ = 0; #1;
    chk("midrst_r5", rd1, 32'h0);
    #1 rst_ = 1; #1;
    chk("post_rst_r5", rd1, 32'h0);
    chk("post_rst_hi", hi, 32'h0);
    chk("post_rst_lo", lo, 32'h0);

    // Write then read next cycle; disabled port returns zero.
    cyc();
    wreg = 1; waddr = 7; wdata = 32'h1234_5678; ra1 = 6; ra2 = 6;
    cyc(); idle(); ra1 = 7; #2;
    chk("r7_read", rd1, 32'h1234_5678);
    re1 = 0; #1;
    chk("r7_re0", rd1, 32'h0);
    re1 = 1;

    // Writes to r0 are discarded and r0 reads zero even with bypass.
    cyc();
    wreg = 1; waddr = 0; wdata = 32'hFFFF_FFFF; ra1 = 0; ra2 = 0; #2;
    chk("r0_same_p1", rd1, 32'h0);
    chk("r0_same_p2", rd2, 32'h0);
    cyc(); idle(); #2;
    chk("r0_next_p1", rd1, 32'h0);
    chk("r0_next_p2", rd2, 32'h0);

    // Bypass over stored value.
    cyc();
    wreg = 1; waddr = 3; wdata = 32'hAAAA_0000;
    cyc(); idle(); ra1 = 3; ra2 = 3; #2;
    chk("r3_stored", rd1, 32'hAAAA_0000);
    cyc();
    wreg = 1; waddr = 3; wdata = 32'h0000_5555; #2;
    chk("byp_p1", rd1, 32'h0000_5555);
    chk("byp_p2", rd2, 32'h0000_5555);
    cyc(); idle(); #2;
    chk("byp_stored", rd2, 32'h0000_5555);

    // Back-to-back writes to one index: last wins.
    cyc();
    wreg = 1; waddr = 4; wdata = 32'h11; ra1 = 4; ra2 = 9;
    cyc();
    wdata = 32'h22; #2;
    chk("b2b_byp", rd1, 32'h22);
    cyc(); idle(); #2;
    chk("b2b_stored", rd1, 32'h22);

    // HI/LO with simultaneous GPR write.
    cyc();
    we_hilo = 1; whi = 32'h1; wlo = 32'h2; wreg = 1; waddr = 9; wdata = 32'h9; #2;
    chk("hilo_byp_hi", hi, 32'h1);
    chk("hilo_byp_lo", lo, 32'h2);
    cyc(); idle(); #2;
    chk("hilo_hold_hi", hi, 32'h1);
    chk("hilo_hold_lo", lo, 32'h2);
    chk("r9_commit", rd2, 32'h9);

    // Random run against a reference model from a clean reset.
    cyc();
    rst_ = 0; #1 rst_ = 1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mhi = 0; mlo = 0;
    for (int c = 0; c < 10000; c++) begin
      cyc();
      wreg    = 1'($urandom_range(0, 1));
      waddr   = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wdata   = $urandom;
      we_hilo = 1'($urandom_range(0, 1));
      whi     = $urandom;
      wlo     = $urandom;
      re1     = ($urandom_range(0, 7) != 0);
      re2     = ($urandom_range(0, 7) != 0);
      ra1     = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ra2     = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      #2;
      chk("rnd_rd1", rd1, exp_rd(re1, ra1));
      chk("rnd_rd2", rd2, exp_rd(re2, ra2));
      chk("rnd_hi", hi, we_hilo ? whi : mhi);
      chk("rnd_lo", lo, we_hilo ? wlo : mlo);
      if (wreg && waddr != 5'd0) mdl[waddr] = wdata;
      if (we_hilo) begin
        mhi = whi;
        mlo = wlo;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the MEM/WB pipeline interface. Consumes the registered write-back bundle (GPR write and HI/LO write) and commits it to architectural state: a 32×32-bit general-purpose register file and the HI/LO register pair. It also serves the decode stage's two GPR read ports and the execute stage's HI/LO read, with same-cycle write-through bypass so no extra forwarding is needed for the WB→ID hazard.

## Interface

Parameters:
- DATA_W, 32, GPR / HI / LO data width
- ADDR_W, 5, GPR address width (REG_NUM = 2**ADDR_W = 32)

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_  input  1  asynchronous, active-low reset
- wb_i_waddr  input  ADDR_W  GPR destination index
- wb_i_wreg  input  1  GPR write enable
- wb_i_wdata  input  DATA_W  GPR write data
- wb_i_we_hilo  input  1  HI/LO write enable (writes both)
- wb_i_wdata_hi  input  DATA_W  HI write data
- wb_i_wdata_lo  input  DATA_W  LO write data
- id_re1, id_re2  input  1 each  read enables, ports 1/2
- id_raddr1, id_raddr2  input  ADDR_W each  read indices
- id_rdata1, id_rdata2  output  DATA_W each  read data (combinational)
- hi_o, lo_o  output  DATA_W each  current HI/LO value (combinational, bypassed)

## Operation

- Reset (rst_=0, asynchronous): all 32 GPRs, HI, LO cleared to 0; held while rst_=0; writes ignored. Combinational outputs during reset = 0.
- GPR write: at posedge clk, if wb_i_wreg=1 and wb_i_waddr≠0, gpr[wb_i_waddr] ← wb_i_wdata. Writes to index 0 discarded.
- GPR read, per port n, priority order:
  1. id_ren=0 → 0.
  2. id_raddrn=0 → 0 (hardwired zero, even if a write to 0 is pending).
  3. wb_i_wreg=1 and wb_i_waddr=id_raddrn → wb_i_wdata (bypass).
  4. otherwise → gpr[id_raddrn].
- Both ports independent; same address on both ports returns identical data.
- HI/LO write: at posedge clk, if wb_i_we_hilo=1, HI ← wb_i_wdata_hi and LO ← wb_i_wdata_lo. No partial write.
- HI/LO read: wb_i_we_hilo=1 → hi_o/lo_o = wb_i_wdata_hi/lo; else stored HI/LO.
- GPR and HI/LO paths fully independent; simultaneous GPR and HI/LO writes both commit.

## Timing

- Write latency: 1 cycle; value visible from storage the cycle after the edge, visible via bypass in the same cycle the write bundle is presented.
- Read latency: 0 (combinational from raddr/re and wb_i_* to rdata, hi_o, lo_o).
- No handshake; wb_i_* treated as valid whenever enables are high.
- Reset assertion mid-cycle clears state immediately; the first write after deassertion commits at the first rising edge with rst_=1.
- Back-to-back writes to same index: last write wins; read in the second cycle bypasses the second write's data.

## Structure

- Shared package (pipeline-wide): DATA_W, ADDR_W, REG_NUM, ZERO_WORD constants; reused by ID/EX/MEM/WB blocks.
- Sub-module hilo_reg: HI/LO storage and bypass mux (enable, two data in, two data out); instantiated once.
- GPR array and read muxes inline in wb_regfile.

## Test plan

- Reset: drive rst_=0 mid-run after writing gpr[5]=0xDEADBEEF, HI=1 → after release, read r5 = 0, hi_o = 0, lo_o = 0.
- Write/read: write r7=0x12345678 in cycle N; cycle N+1, raddr1=7, re1=1 → rdata1=0x12345678; re1=0 → rdata1=0.
- Zero register: write r0=0xFFFFFFFF with wreg=1 → same-cycle and next-cycle read of r0 on both ports = 0.
- Bypass: r3 holds 0xAAAA0000; present wreg=1, waddr=3, wdata=0x5555 while raddr1=raddr2=3 → both ports = 0x5555 that cycle, and 0x5555 from storage next cycle.
- HI/LO: we_hilo=1, hi=0x1, lo=0x2 → hi_o=1, lo_o=2 same cycle; we_hilo=0 next cycle → still 1/2; simultaneous GPR write r9=0x9 also commits.
- Random: 10k cycles of random writes/reads against a reference model including bypass and r0 rules → zero mismatches.
